// File: rtl/fetdriver_deadtime_sequencer_if.sv
// Control/status bundle between the PWM logic (master) and the half-bridge
// dead-time sequencer (slave).
interface fetdriver_deadtime_sequencer_if;
  logic       drv_en;
  logic       pwm;
  logic       fault;
  logic       fault_clr;
  logic       top_en_ls;
  logic       top_in;
  logic       bot_en_ls;
  logic       bot_in;
  logic       ready;
  logic       fault_latched;
  logic [2:0] state;

  modport master (
    output drv_en, pwm, fault, fault_clr,
    input  top_en_ls, top_in, bot_en_ls, bot_in, ready, fault_latched, state
  );

  modport slave (
    input  drv_en, pwm, fault, fault_clr,
    output top_en_ls, top_in, bot_en_ls, bot_in, ready, fault_latched, state
  );
endinterface

// File: rtl/fetdriver_deadtime_sequencer.sv
// Enable/data sequencer for the top and bottom fetdriver logic shifters of one
// half-bridge leg: shifter warm-up, break-before-make dead time, latched fault.
// Optional build macro: FETSEQ_MINON_EN (hold each conduction state for at
// least MINON_CYC cycles before acting on a pwm change).
module fetdriver_deadtime_sequencer #(
  parameter int unsigned DT_CYC     = 4,
  parameter int unsigned WARMUP_CYC = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MINON_CYC  = 3
) (
  input logic                           CELCLK,
  input logic                           CELRST,
  fetdriver_deadtime_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StWarmup = 3'd1,
    StBotOn  = 3'd2,
    StDtTop  = 3'd3,
    StTopOn  = 3'd4,
    StDtBot  = 3'd5,
    StFault  = 3'd6
  } state_e;

`ifdef FETSEQ_MINON_EN
  localparam bit MinonEnable = 1'b1;
`else
  localparam bit MinonEnable = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] WarmupLoad = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] DtLoad     = CNT_W'(DT_CYC - 1);
  // With the minimum-on feature off the conduction states load 0, so the
  // hold check below never delays a pwm change.
  localparam logic [CNT_W-1:0] HoldLoad   = MinonEnable ? CNT_W'(MINON_CYC - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               top_en_q, bot_en_q;
  logic               top_in_q, bot_in_q;
  logic               ready_q, fault_q;

  // Next state and counter: fault beats drv_en low, which beats sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q > StFault) begin
      // Unused encoding: recover through OFF.
      state_d = StOff;
      cnt_d   = '0;
    end else if (state_q == StFault) begin
      // Clear is honoured only once the fault source itself has gone away.
      if (bus.fault_clr && !bus.fault) begin
        state_d = StOff;
        cnt_d   = '0;
      end
    end else if (bus.fault) begin
      state_d = StFault;
      cnt_d   = '0;
    end else if (!bus.drv_en) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StWarmup;
          cnt_d   = WarmupLoad;
        end
        StWarmup: begin
          // Bottom switch conducts first so the bootstrap cap gets charged.
          if (cnt_q == '0) begin
            state_d = StBotOn;
            cnt_d   = HoldLoad;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StBotOn: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
          end else if (bus.pwm) begin
            state_d = StDtTop;
            cnt_d   = DtLoad;
          end
        end
        StDtTop: begin
          // Top never conducted, so an aborted request goes straight back.
          if (!bus.pwm) begin
            state_d = StBotOn;
            cnt_d   = HoldLoad;
          end else if (cnt_q == '0) begin
            state_d = StTopOn;
            cnt_d   = HoldLoad;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StTopOn: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
          end else if (!bus.pwm) begin
            state_d = StDtBot;
            cnt_d   = DtLoad;
          end
        end
        StDtBot: begin
          if (bus.pwm) begin
            state_d = StTopOn;
            cnt_d   = HoldLoad;
          end else if (cnt_q == '0) begin
            state_d = StBotOn;
            cnt_d   = HoldLoad;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; outputs decode the state being entered.
  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state_q  <= StOff;
      cnt_q    <= '0;
      top_en_q <= 1'b0;
      bot_en_q <= 1'b0;
      top_in_q <= 1'b0;
      bot_in_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Shifters stay enabled in FAULT so their outputs are driven low, not floated.
      top_en_q <= (state_d != StOff);
      bot_en_q <= (state_d != StOff);
      top_in_q <= (state_d == StTopOn);
      bot_in_q <= (state_d == StBotOn);
      ready_q  <= (state_d == StBotOn) || (state_d == StDtTop) ||
                  (state_d == StTopOn) || (state_d == StDtBot);
      fault_q  <= (state_d == StFault);
    end
  end

  assign bus.top_en_ls     = top_en_q;
  assign bus.bot_en_ls     = bot_en_q;
  assign bus.top_in        = top_in_q;
  assign bus.bot_in        = bot_in_q;
  assign bus.ready         = ready_q;
  assign bus.fault_latched = fault_q;
  assign bus.state         = state_q;

endmodule
